issue_scheduler: RTL and testbench
==================================

# issue_scheduler

Out-of-order issue queue between the rename stage and the functional units. It holds renamed instructions and tracks per-operand PRN readiness from FU wakeup broadcasts. Each cycle it selects, for every FU, the oldest resident instruction targeting that FU whose operands are all ready, and hands it off over a valid/ready handshake. It shares the FU and PRF read ports among waiting instructions.

## Interface
- ENTRIES, 8, queue slots (power of two, ≥2)
- FU_COUNT, 4, functional units / issue ports
- MAX_OPERANDS, 3, source and destination operand slots per instruction
- PRN_BITS, 6, physical register number width
- INST_ID_BITS, 6, ROB instruction id width
- FUC_BITS, $clog2(FU_COUNT), FU choice width

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (pipeline flush)
- in_valid  in  1  rename stage offers an instruction
- in_ready  out  1  a free slot exists
- in_inst_id  in  INST_ID_BITS  ROB id
- in_raw_instr  in  32  raw encoding
- in_instr_pc  in  64  PC
- in_fu_choice  in  FUC_BITS  target FU
- in_prn_input_valid[MAX_OPERANDS]  in  1  source operand used
- in_prn_input_ready[MAX_OPERANDS]  in  1  source already ready at rename
- in_prn_input[MAX_OPERANDS]  in  PRN_BITS  source PRNs
- in_prn_output_valid[MAX_OPERANDS]  in  1  destination used
- in_prn_output[MAX_OPERANDS]  in  PRN_BITS  destination PRNs
- set_prn_ready_valid[MAX_OPERANDS]  in  1  wakeup broadcast valid
- set_prn_ready[MAX_OPERANDS]  in  PRN_BITS  PRN becoming ready
- issue_valid[FU_COUNT]  out  1  instruction offered to FU f
- issue_ready[FU_COUNT]  in  1  FU f accepts
- issue_inst_id[FU_COUNT], issue_raw_instr[FU_COUNT], issue_instr_pc[FU_COUNT]  out  as input widths
- issue_prn_input[FU_COUNT][MAX_OPERANDS], issue_prn_input_valid[FU_COUNT][MAX_OPERANDS], issue_prn_output[FU_COUNT][MAX_OPERANDS], issue_prn_output_valid[FU_COUNT][MAX_OPERANDS]  out  PRN_BITS / 1

## Operation
- Entry state: valid, payload, per-source rdy bit, age relation to every other entry.
- Dispatch: in_valid && in_ready writes the lowest-index free slot; rdy[k] = !in_prn_input_valid[k] || in_prn_input_ready[k] || (PRN matches a same-cycle broadcast).
- Wakeup: every valid entry with a source matching any valid broadcast sets that rdy bit. Unused sources are always ready.
- Eligible(e, f): valid && fu_choice == f && all rdy bits set. Per FU, select the eligible entry dispatched earliest. Age order is strict, with no ties.
- issue_valid[f] = eligible entry exists. Payload fields come from the selected entry and are zero when issue_valid[f] = 0.
- The selection may change between cycles while not accepted. FUs must sample only on handshake.
- Handshake: issue_valid[f] && issue_ready[f] frees the entry at the clock edge. At most one issue per FU per cycle. Different FUs issue in parallel.
- in_ready = at least one free slot in registered state. A same-cycle issue does not raise it.
- flush: all entries invalidated at the edge. Dispatch in that cycle is dropped. issue_valid is still driven from pre-flush state that cycle; handshakes in the flush cycle are acknowledged but irrelevant.
- Reset/flush priority: rst > flush > dispatch/issue.

## Timing
- Reset values: all entries invalid, issue_valid = 0, payload outputs 0. in_ready = 1 from the first cycle after rst deasserts.
- Dispatch at edge N: the entry is eligible for issue in cycle N+1 at the earliest.
- Wakeup in cycle N: the dependent entry can issue in cycle N+1.
- A slot freed at edge N is visible through in_ready in cycle N+1.
- Full queue: in_ready = 0. in_valid is ignored and must be held by the producer.
- Issue outputs are combinational from registered state only; there is no input-to-output path on issue ports.

## Structure
- Shared package ooo_pkg: MAX_OPERANDS, PRN_BITS, INST_ID_BITS, FU_COUNT, FUC_BITS, and the issue-entry struct typedef.
- Age tracking: an ENTRIES×ENTRIES age matrix. A dispatch row is set older-than-none; a freed entry clears its column.
- Sub-module oldest_ready_select: takes an eligible vector and the age matrix, and returns a one-hot grant. Instantiate it once per FU.

## Test plan
- Reset, then dispatch inst_id 5, FU 1, all sources ready → issue_valid[1] = 1 next cycle with inst_id 5; freed after issue_ready[1].
- Dispatch id 3 (src PRN 12 not ready), then id 4 (ready), both on FU 0 → id 4 issues first. Broadcast PRN 12 → id 3 issues the following cycle.
- Fill all 8 slots with FU 2 blocked → in_ready = 0, in_valid ignored. One issue → in_ready = 1 next cycle, no entries lost.
- Broadcast PRN 20 in the same cycle as dispatch of id 7 sourcing PRN 20 → id 7 issues next cycle.
- Two eligible entries on FU 0 and FU 3 → both issue in the same cycle. The oldest wins per FU when multiple are eligible.
- Flush with 5 entries resident and a concurrent dispatch → next cycle all issue_valid = 0, in_ready = 1, and the dispatched instruction is absent.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types and widths for the issue queue and its users.
package ooo_pkg;

  localparam int unsigned MAX_OPERANDS = 3;
  localparam int unsigned PRN_BITS     = 6;
  localparam int unsigned INST_ID_BITS = 6;
  localparam int unsigned FU_COUNT     = 4;
  localparam int unsigned FUC_BITS     = $clog2(FU_COUNT);

  // Payload carried by one issue-queue slot and presented on an issue port.
  typedef struct packed {
    logic [INST_ID_BITS-1:0]                  inst_id;
    logic [31:0]                              raw_instr;
    logic [63:0]                              instr_pc;
    logic [FUC_BITS-1:0]                      fu_choice;
    logic [MAX_OPERANDS-1:0]                  src_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    src_prn;
    logic [MAX_OPERANDS-1:0]                  dst_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    dst_prn;
  } issue_entry_t;

endpackage

// File: rtl/oldest_ready_select.sv
// Grants the oldest eligible entry; age_i[j][e] set means entry j is older than entry e.
module oldest_ready_select #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic [ENTRIES-1:0] eligible_i,
  input  logic [ENTRIES-1:0] age_i [ENTRIES],
  output logic [ENTRIES-1:0] grant_o
);

  logic [ENTRIES-1:0] blocked_c;

  // An entry is blocked when any older entry is also eligible.
  always_comb begin
    blocked_c = '0;
    grant_o   = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        blocked_c[e] = blocked_c[e] | (eligible_i[j] & age_i[j][e]);
      end
      grant_o[e] = eligible_i[e] & ~blocked_c[e];
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue queue: holds renamed instructions, tracks operand readiness
// from wakeup broadcasts and issues the oldest ready instruction to each FU.
module issue_scheduler
  import ooo_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INST_ID_BITS-1:0] in_inst_id,
  input  logic [31:0]             in_raw_instr,
  input  logic [63:0]             in_instr_pc,
  input  logic [FUC_BITS-1:0]     in_fu_choice,
  input  logic                    in_prn_input_valid  [MAX_OPERANDS],
  input  logic                    in_prn_input_ready  [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     in_prn_input        [MAX_OPERANDS],
  input  logic                    in_prn_output_valid [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     in_prn_output       [MAX_OPERANDS],
  input  logic                    set_prn_ready_valid [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     set_prn_ready       [MAX_OPERANDS],
  output logic                    issue_valid         [FU_COUNT],
  input  logic                    issue_ready         [FU_COUNT],
  output logic [INST_ID_BITS-1:0] issue_inst_id       [FU_COUNT],
  output logic [31:0]             issue_raw_instr     [FU_COUNT],
  output logic [63:0]             issue_instr_pc      [FU_COUNT],
  output logic [PRN_BITS-1:0]     issue_prn_input        [FU_COUNT][MAX_OPERANDS],
  output logic                    issue_prn_input_valid  [FU_COUNT][MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     issue_prn_output       [FU_COUNT][MAX_OPERANDS],
  output logic                    issue_prn_output_valid [FU_COUNT][MAX_OPERANDS]
);

  localparam int unsigned IDX_BITS = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]      valid_q, valid_d;
  issue_entry_t            entry_q [ENTRIES];
  issue_entry_t            entry_d [ENTRIES];
  logic [MAX_OPERANDS-1:0] rdy_q   [ENTRIES];
  logic [MAX_OPERANDS-1:0] rdy_d   [ENTRIES];
  logic [ENTRIES-1:0]      age_q   [ENTRIES];
  logic [ENTRIES-1:0]      age_d   [ENTRIES];
  logic                    free_q;

  logic [MAX_OPERANDS-1:0]               bc_valid_c;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] bc_prn_c;
  logic [IDX_BITS-1:0]                   alloc_idx_c;
  logic                                  dispatch_c;
  issue_entry_t                          new_entry_c;
  logic [MAX_OPERANDS-1:0]               new_rdy_c;
  logic [ENTRIES-1:0]                    elig_c  [FU_COUNT];
  logic [ENTRIES-1:0]                    grant_c [FU_COUNT];
  logic [ENTRIES-1:0]                    issued_c;
  issue_entry_t                          sel_c   [FU_COUNT];

  function automatic logic wake_hit(
    input logic [PRN_BITS-1:0]                  prn,
    input logic [MAX_OPERANDS-1:0]              bv,
    input logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] bp
  );
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < MAX_OPERANDS; b++) begin
      hit = hit | (bv[b] & (bp[b] == prn));
    end
    return hit;
  endfunction

  assign in_ready   = free_q;
  assign dispatch_c = in_valid & free_q & ~flush;

  always_comb begin
    bc_valid_c = '0;
    bc_prn_c   = '0;
    for (int b = 0; b < MAX_OPERANDS; b++) begin
      bc_valid_c[b] = set_prn_ready_valid[b];
      bc_prn_c[b]   = set_prn_ready[b];
    end
  end

  // Lowest-index free slot receives the next dispatch.
  always_comb begin
    alloc_idx_c = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (!valid_q[e]) alloc_idx_c = IDX_BITS'(e);
    end
  end

  always_comb begin
    new_entry_c           = '0;
    new_rdy_c             = '0;
    new_entry_c.inst_id   = in_inst_id;
    new_entry_c.raw_instr = in_raw_instr;
    new_entry_c.instr_pc  = in_instr_pc;
    new_entry_c.fu_choice = in_fu_choice;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      new_entry_c.src_valid[k] = in_prn_input_valid[k];
      new_entry_c.src_prn[k]   = in_prn_input[k];
      new_entry_c.dst_valid[k] = in_prn_output_valid[k];
      new_entry_c.dst_prn[k]   = in_prn_output[k];
      new_rdy_c[k] = ~in_prn_input_valid[k] | in_prn_input_ready[k] |
                     wake_hit(in_prn_input[k], bc_valid_c, bc_prn_c);
    end
  end

  always_comb begin
    for (int f = 0; f < FU_COUNT; f++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        elig_c[f][e] = valid_q[e] & (entry_q[e].fu_choice == FUC_BITS'(f)) & (&rdy_q[e]);
      end
    end
  end

  for (genvar f = 0; f < FU_COUNT; f++) begin : g_sel
    oldest_ready_select #(.ENTRIES(ENTRIES)) u_select (
      .eligible_i (elig_c[f]),
      .age_i      (age_q),
      .grant_o    (grant_c[f])
    );
  end

  always_comb begin
    issued_c = '0;
    for (int f = 0; f < FU_COUNT; f++) begin
      issued_c = issued_c | (grant_c[f] & {ENTRIES{issue_ready[f]}});
    end
  end

  // Next state: wakeup, issue frees, dispatch, then flush overrides validity.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    rdy_d   = rdy_q;
    age_d   = age_q;
    for (int e = 0; e < ENTRIES; e++) begin
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        if (wake_hit(entry_q[e].src_prn[k], bc_valid_c, bc_prn_c)) rdy_d[e][k] = 1'b1;
      end
    end
    for (int e = 0; e < ENTRIES; e++) begin
      if (issued_c[e]) begin
        valid_d[e] = 1'b0;
        for (int i = 0; i < ENTRIES; i++) age_d[i][e] = 1'b0;
      end
    end
    if (dispatch_c) begin
      valid_d[alloc_idx_c] = 1'b1;
      entry_d[alloc_idx_c] = new_entry_c;
      rdy_d[alloc_idx_c]   = new_rdy_c;
      age_d[alloc_idx_c]   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        age_d[i][alloc_idx_c] = valid_q[i] & ~issued_c[i];
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      free_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      free_q  <= ~&valid_d;
    end
  end

  // Payload, readiness and age are only meaningful under valid_q.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
    rdy_q   <= rdy_d;
    age_q   <= age_d;
  end

  always_comb begin
    for (int f = 0; f < FU_COUNT; f++) begin
      sel_c[f] = '0;
      for (int e = 0; e < ENTRIES; e++) begin
        if (grant_c[f][e]) sel_c[f] = entry_q[e];
      end
    end
  end

  always_comb begin
    for (int f = 0; f < FU_COUNT; f++) begin
      issue_valid[f]     = |grant_c[f];
      issue_inst_id[f]   = sel_c[f].inst_id;
      issue_raw_instr[f] = sel_c[f].raw_instr;
      issue_instr_pc[f]  = sel_c[f].instr_pc;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        issue_prn_input[f][k]        = sel_c[f].src_prn[k];
        issue_prn_input_valid[f][k]  = sel_c[f].src_valid[k];
        issue_prn_output[f][k]       = sel_c[f].dst_prn[k];
        issue_prn_output_valid[f][k] = sel_c[f].dst_valid[k];
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with hand-computed expectations.
module tb_issue_scheduler;
  import ooo_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [INST_ID_BITS-1:0] in_inst_id;
  logic [31:0]             in_raw_instr;
  logic [63:0]             in_instr_pc;
  logic [FUC_BITS-1:0]     in_fu_choice;
  logic                    in_prn_input_valid  [MAX_OPERANDS];
  logic                    in_prn_input_ready  [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     in_prn_input        [MAX_OPERANDS];
  logic                    in_prn_output_valid [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     in_prn_output       [MAX_OPERANDS];
  logic                    set_prn_ready_valid [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     set_prn_ready       [MAX_OPERANDS];
  logic                    issue_valid         [FU_COUNT];
  logic                    issue_ready         [FU_COUNT];
  logic [INST_ID_BITS-1:0] issue_inst_id       [FU_COUNT];
  logic [31:0]             issue_raw_instr     [FU_COUNT];
  logic [63:0]             issue_instr_pc      [FU_COUNT];
  logic [PRN_BITS-1:0]     issue_prn_input        [FU_COUNT][MAX_OPERANDS];
  logic                    issue_prn_input_valid  [FU_COUNT][MAX_OPERANDS];
  logic [PRN_BITS-1:0]     issue_prn_output       [FU_COUNT][MAX_OPERANDS];
  logic                    issue_prn_output_valid [FU_COUNT][MAX_OPERANDS];

  int checks = 0;
  int errors = 0;

  issue_scheduler #(.ENTRIES(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .flush                  (flush),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_inst_id             (in_inst_id),
    .in_raw_instr           (in_raw_instr),
    .in_instr_pc            (in_instr_pc),
    .in_fu_choice           (in_fu_choice),
    .in_prn_input_valid     (in_prn_input_valid),
    .in_prn_input_ready     (in_prn_input_ready),
    .in_prn_input           (in_prn_input),
    .in_prn_output_valid    (in_prn_output_valid),
    .in_prn_output          (in_prn_output),
    .set_prn_ready_valid    (set_prn_ready_valid),
    .set_prn_ready          (set_prn_ready),
    .issue_valid            (issue_valid),
    .issue_ready            (issue_ready),
    .issue_inst_id          (issue_inst_id),
    .issue_raw_instr        (issue_raw_instr),
    .issue_instr_pc         (issue_instr_pc),
    .issue_prn_input        (issue_prn_input),
    .issue_prn_input_valid  (issue_prn_input_valid),
    .issue_prn_output       (issue_prn_output),
    .issue_prn_output_valid (issue_prn_output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction; source 0 uses prn, destination 0 gets id+1.
  task automatic offer(input int id, input int fu, input int prn, input logic rdy0);
    in_valid      = 1'b1;
    in_inst_id    = INST_ID_BITS'(id);
    in_raw_instr  = 32'h0000_1000 | 32'(id);
    in_instr_pc   = 64'h8000_0000 + 64'(id * 4);
    in_fu_choice  = FUC_BITS'(fu);
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      in_prn_input_valid[k]  = 1'b0;
      in_prn_input_ready[k]  = 1'b0;
      in_prn_input[k]        = '0;
      in_prn_output_valid[k] = 1'b0;
      in_prn_output[k]       = '0;
    end
    in_prn_input_valid[0]  = 1'b1;
    in_prn_input_ready[0]  = rdy0;
    in_prn_input[0]        = PRN_BITS'(prn);
    in_prn_output_valid[0] = 1'b1;
    in_prn_output[0]       = PRN_BITS'(id + 1);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      set_prn_ready_valid[k] = 1'b0;
      set_prn_ready[k]       = '0;
    end
    for (int f = 0; f < FU_COUNT; f++) issue_ready[f] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    offer(0, 0, 0, 1'b1);
    idle_inputs();
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    for (int f = 0; f < FU_COUNT; f++) begin
      chk("rst_issue_valid", 64'(issue_valid[f]), 64'd0);
      chk("rst_inst_id", 64'(issue_inst_id[f]), 64'd0);
    end

    // Single ready instruction on FU 1
    offer(5, 1, 0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t1_valid1", 64'(issue_valid[1]), 64'd1);
    chk("t1_id1", 64'(issue_inst_id[1]), 64'd5);
    chk("t1_pc1", issue_instr_pc[1], 64'h8000_0014);
    chk("t1_raw1", 64'(issue_raw_instr[1]), 64'h1005);
    chk("t1_dst1", 64'(issue_prn_output[1][0]), 64'd6);
    chk("t1_dstv1", 64'(issue_prn_output_valid[1][0]), 64'd1);
    chk("t1_valid0", 64'(issue_valid[0]), 64'd0);
    chk("t1_id0_zero", 64'(issue_inst_id[0]), 64'd0);
    issue_ready[1] = 1'b1;
    step();
    issue_ready[1] = 1'b0;
    chk("t1_freed", 64'(issue_valid[1]), 64'd0);

    // Younger ready instruction bypasses older blocked one; wakeup releases it
    offer(3, 0, 12, 1'b0);
    step();
    chk("t2_blocked", 64'(issue_valid[0]), 64'd0);
    offer(4, 0, 0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t2_valid_a", 64'(issue_valid[0]), 64'd1);
    chk("t2_id4", 64'(issue_inst_id[0]), 64'd4);
    issue_ready[0] = 1'b1;
    step();
    issue_ready[0] = 1'b0;
    chk("t2_wait", 64'(issue_valid[0]), 64'd0);
    set_prn_ready_valid[1] = 1'b1;
    set_prn_ready[1]       = 6'd12;
    step();
    set_prn_ready_valid[1] = 1'b0;
    chk("t2_valid_b", 64'(issue_valid[0]), 64'd1);
    chk("t2_id3", 64'(issue_inst_id[0]), 64'd3);
    chk("t2_src", 64'(issue_prn_input[0][0]), 64'd12);
    chk("t2_srcv", 64'(issue_prn_input_valid[0][0]), 64'd1);
    issue_ready[0] = 1'b1;
    step();
    issue_ready[0] = 1'b0;

    // Broadcast in the same cycle as dispatch
    offer(7, 3, 20, 1'b0);
    set_prn_ready_valid[0] = 1'b1;
    set_prn_ready[0]       = 6'd20;
    step();
    in_valid = 1'b0;
    set_prn_ready_valid[0] = 1'b0;
    chk("t4_valid3", 64'(issue_valid[3]), 64'd1);
    chk("t4_id7", 64'(issue_inst_id[3]), 64'd7);
    issue_ready[3] = 1'b1;
    step();
    issue_ready[3] = 1'b0;

    // Parallel issue on FU 0 and FU 3, oldest wins on FU 0
    offer(10, 0, 0, 1'b1);
    step();
    offer(11, 0, 0, 1'b1);
    step();
    offer(12, 3, 0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t5_valid0", 64'(issue_valid[0]), 64'd1);
    chk("t5_id10", 64'(issue_inst_id[0]), 64'd10);
    chk("t5_valid3", 64'(issue_valid[3]), 64'd1);
    chk("t5_id12", 64'(issue_inst_id[3]), 64'd12);
    issue_ready[0] = 1'b1;
    issue_ready[3] = 1'b1;
    step();
    issue_ready[0] = 1'b0;
    issue_ready[3] = 1'b0;
    chk("t5_id11", 64'(issue_inst_id[0]), 64'd11);
    chk("t5_fu3_empty", 64'(issue_valid[3]), 64'd0);
    issue_ready[0] = 1'b1;
    step();
    issue_ready[0] = 1'b0;
    chk("t5_fu0_empty", 64'(issue_valid[0]), 64'd0);

    // Fill all slots with FU 2 stalled
    for (int i = 0; i < 8; i++) begin
      chk("t3_ready_fill", 64'(in_ready), 64'd1);
      offer(20 + i, 2, 0, 1'b1);
      step();
    end
    chk("t3_full", 64'(in_ready), 64'd0);
    chk("t3_oldest", 64'(issue_inst_id[2]), 64'd20);
    offer(28, 2, 0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t3_still_full", 64'(in_ready), 64'd0);
    issue_ready[2] = 1'b1;
    step();
    issue_ready[2] = 1'b0;
    chk("t3_ready_again", 64'(in_ready), 64'd1);
    for (int i = 0; i < 7; i++) begin
      chk("t3_drain_valid", 64'(issue_valid[2]), 64'd1);
      chk("t3_drain_id", 64'(issue_inst_id[2]), 64'(21 + i));
      issue_ready[2] = 1'b1;
      step();
      issue_ready[2] = 1'b0;
    end
    chk("t3_drained", 64'(issue_valid[2]), 64'd0);

    // Flush with five resident entries and a concurrent dispatch
    for (int i = 0; i < 5; i++) begin
      offer(40 + i, 1, 0, 1'b1);
      step();
    end
    chk("t6_pre_valid", 64'(issue_valid[1]), 64'd1);
    chk("t6_pre_id", 64'(issue_inst_id[1]), 64'd40);
    offer(45, 0, 0, 1'b1);
    flush = 1'b1;
    chk("t6_flush_cycle", 64'(issue_valid[1]), 64'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    for (int f = 0; f < FU_COUNT; f++) begin
      chk("t6_issue_valid", 64'(issue_valid[f]), 64'd0);
      chk("t6_inst_id", 64'(issue_inst_id[f]), 64'd0);
      chk("t6_raw", 64'(issue_raw_instr[f]), 64'd0);
      chk("t6_pc", issue_instr_pc[f], 64'd0);
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        chk("t6_src", 64'(issue_prn_input[f][k]), 64'd0);
        chk("t6_srcv", 64'(issue_prn_input_valid[f][k]), 64'd0);
        chk("t6_dst", 64'(issue_prn_output[f][k]), 64'd0);
        chk("t6_dstv", 64'(issue_prn_output_valid[f][k]), 64'd0);
      end
    end
    step();
    chk("t6_no_id45", 64'(issue_valid[0]), 64'd0);
    chk("t6_in_ready2", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
